l1_tlb_mp: RTL and testbench

//  Multi-port, fully associative L1 TLB for Sv32-style paging; successor of the single-port L1 TLB.

---
 rtl/l1_tlb_mp.sv | 243 ++++++++++++++++++++++++
 tb/tb_l1_tlb_mp.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_tlb_mp.sv
`default_nettype none
// ============================================================================
//  Module   : l1_tlb_mp
//  Purpose  : Multi-port, fully associative L1 TLB for Sv32-style paging.
//             ASID tagging with a global bit and superpage support. Internal
//             victim selection (duplicate, then invalid-first, then round-robin).
//             SFENCE.VMA flush by all / vaddr / asid / vaddr+asid.
//  Ports    : clk, rst (async, active-high)
//             lk_req/lk_vaddr          -> lookup request per port
//             lk_miss/lk_exc/lk_paddr  <- registered lookup result per port
//             priv, satp_mode, satp_asid, sum  -> translation context
//             fill_*                   -> fill from L2 TLB / PTW
//             flush_*                  -> SFENCE.VMA request
//  Revision : 1.0  initial multi-port release
// ============================================================================
module l1_tlb_mp #(
  parameter int DEPTH  = 16,
  parameter int PORTS  = 2,
  parameter int LEVELS = 2,
  parameter int PN_W   = 10,
  parameter int PPN_W  = 22,
  parameter int ASID_W = 9,
  parameter int OFFSET = 12,
  parameter int SIZE_W = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORTS-1:0]                      lk_req,
  input  logic [PORTS*(LEVELS*PN_W+OFFSET)-1:0] lk_vaddr,
  output logic [PORTS-1:0]                      lk_miss,
  output logic [PORTS-1:0]                      lk_exc,
  output logic [PORTS*(PPN_W+OFFSET)-1:0]       lk_paddr,
  input  logic [1:0]                            priv,
  input  logic                                  satp_mode,
  input  logic [ASID_W-1:0]                     satp_asid,
  input  logic                                  sum,
  input  logic                                  fill_we,
  input  logic [LEVELS*PN_W-1:0]                fill_vpn,
  input  logic [ASID_W-1:0]                     fill_asid,
  input  logic [PPN_W-1:0]                      fill_ppn,
  input  logic [SIZE_W-1:0]                     fill_size,
  input  logic                                  fill_g,
  input  logic                                  fill_u,
  input  logic                                  flush_valid,
  input  logic                                  flush_use_va,
  input  logic                                  flush_use_as,
  input  logic [LEVELS*PN_W+OFFSET-1:0]         flush_vaddr,
  input  logic [ASID_W-1:0]                     flush_asid
);

  localparam int c_vpn_w = LEVELS * PN_W;
  localparam int c_va_w  = c_vpn_w + OFFSET;
  localparam int c_pa_w  = PPN_W + OFFSET;
  localparam int c_idx_w = $clog2(DEPTH);

  // Compare vpn fields at or above the entry size; lower fields are the
  // superpage offset and are ignored.
  function automatic logic vpn_match(input logic [c_vpn_w-1:0] a,
                                     input logic [c_vpn_w-1:0] b,
                                     input logic [SIZE_W-1:0]  sz);
    logic eq;
    eq = 1'b1;
    for (int j = 0; j < LEVELS; j++) begin
      if ((j >= int'(sz)) && (a[j*PN_W +: PN_W] != b[j*PN_W +: PN_W])) eq = 1'b0;
    end
    return eq;
  endfunction

  // Low ppn fields of a superpage come from the vaddr. The top ppn field
  // (wider than PN_W) is never masked since size stays below LEVELS.
  function automatic logic [c_pa_w-1:0] translate(input logic [c_va_w-1:0] va,
                                                  input logic [PPN_W-1:0]  ppn,
                                                  input logic [SIZE_W-1:0] sz);
    logic [PPN_W-1:0] pn;
    pn = ppn;
    for (int j = 0; j < LEVELS-1; j++) begin
      if (j < int'(sz)) pn[j*PN_W +: PN_W] = va[OFFSET + j*PN_W +: PN_W];
    end
    return {pn, va[OFFSET-1:0]};
  endfunction

  // Table state
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   g_q, g_d;
  logic [DEPTH-1:0]   u_q, u_d;
  logic [c_vpn_w-1:0] vpn_q  [DEPTH];
  logic [c_vpn_w-1:0] vpn_d  [DEPTH];
  logic [ASID_W-1:0]  asid_q [DEPTH];
  logic [ASID_W-1:0]  asid_d [DEPTH];
  logic [PPN_W-1:0]   ppn_q  [DEPTH];
  logic [PPN_W-1:0]   ppn_d  [DEPTH];
  logic [SIZE_W-1:0]  size_q [DEPTH];
  logic [SIZE_W-1:0]  size_d [DEPTH];
  logic [c_idx_w-1:0] rr_q, rr_d;

  // Registered lookup results
  logic [PORTS-1:0]        lk_miss_q, lk_miss_d;
  logic [PORTS-1:0]        lk_exc_q, lk_exc_d;
  logic [PORTS*c_pa_w-1:0] lk_paddr_q, lk_paddr_d;

  // Lookup scratch
  logic                bypass;
  logic [c_va_w-1:0]   lu_va;
  logic                lu_hit;
  logic [PPN_W-1:0]    lu_ppn;
  logic [SIZE_W-1:0]   lu_size;
  logic                lu_u;

  // Fill / flush scratch
  logic                dup_hit, inv_hit;
  logic [c_idx_w-1:0]  dup_idx, inv_idx, victim;
  logic [c_vpn_w-1:0]  flush_vpn;
  logic                unused_flush_off;

  assign bypass           = (priv == 2'd3) | ~satp_mode;
  assign flush_vpn        = flush_vaddr[OFFSET +: c_vpn_w];
  assign unused_flush_off = ^flush_vaddr[OFFSET-1:0];

  // --------------------------------------------------------------------------
  // Lookup: all ports read the pre-edge table. Scanning from the top down lets
  // the lowest matching index overwrite any higher one.
  // --------------------------------------------------------------------------
  always_comb begin
    lk_miss_d  = '0;
    lk_exc_d   = '0;
    lk_paddr_d = '0;
    lu_va      = '0;
    lu_hit     = 1'b0;
    lu_ppn     = '0;
    lu_size    = '0;
    lu_u       = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      lu_va   = lk_vaddr[p*c_va_w +: c_va_w];
      lu_hit  = 1'b0;
      lu_ppn  = '0;
      lu_size = '0;
      lu_u    = 1'b0;
      for (int e = DEPTH-1; e >= 0; e--) begin
        if (valid_q[e] && (g_q[e] || (asid_q[e] == satp_asid)) &&
            vpn_match(vpn_q[e], lu_va[OFFSET +: c_vpn_w], size_q[e])) begin
          lu_hit  = 1'b1;
          lu_ppn  = ppn_q[e];
          lu_size = size_q[e];
          lu_u    = u_q[e];
        end
      end
      if (bypass) begin
        lk_paddr_d[p*c_pa_w +: c_pa_w] = c_pa_w'(lu_va);
      end else if (lu_hit) begin
        lk_paddr_d[p*c_pa_w +: c_pa_w] = translate(lu_va, lu_ppn, lu_size);
        lk_exc_d[p] = lk_req[p] & (((priv == 2'd1) & ~sum & lu_u) |
                                   ((priv == 2'd0) & ~lu_u));
      end else begin
        lk_miss_d[p] = lk_req[p];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Table update: victim and flush both look at pre-edge valids; the fill is
  // applied last so a freshly filled entry survives a coincident flush.
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    g_d     = g_q;
    u_d     = u_q;
    vpn_d   = vpn_q;
    asid_d  = asid_q;
    ppn_d   = ppn_q;
    size_d  = size_q;
    rr_d    = rr_q;
    dup_hit = 1'b0;
    dup_idx = '0;
    inv_hit = 1'b0;
    inv_idx = '0;

    for (int e = DEPTH-1; e >= 0; e--) begin
      if (valid_q[e] && (size_q[e] == fill_size) && (asid_q[e] == fill_asid) &&
          vpn_match(vpn_q[e], fill_vpn, fill_size)) begin
        dup_hit = 1'b1;
        dup_idx = c_idx_w'(e);
      end
      if (!valid_q[e]) begin
        inv_hit = 1'b1;
        inv_idx = c_idx_w'(e);
      end
    end
    victim = dup_hit ? dup_idx : (inv_hit ? inv_idx : rr_q);

    if (flush_valid) begin
      for (int e = 0; e < DEPTH; e++) begin
        if ((!flush_use_va || vpn_match(vpn_q[e], flush_vpn, size_q[e])) &&
            (!flush_use_as || (!g_q[e] && (asid_q[e] == flush_asid)))) begin
          valid_d[e] = 1'b0;
        end
      end
    end

    if (fill_we) begin
      valid_d[victim] = 1'b1;
      g_d[victim]     = fill_g;
      u_d[victim]     = fill_u;
      vpn_d[victim]   = fill_vpn;
      asid_d[victim]  = fill_asid;
      ppn_d[victim]   = fill_ppn;
      size_d[victim]  = fill_size;
      // Round-robin only advances when it actually picked the victim.
      if (!dup_hit && !inv_hit) rr_d = rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rr_q       <= '0;
      lk_miss_q  <= '0;
      lk_exc_q   <= '0;
      lk_paddr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      lk_miss_q  <= lk_miss_d;
      lk_exc_q   <= lk_exc_d;
      lk_paddr_q <= lk_paddr_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    g_q    <= g_d;
    u_q    <= u_d;
    vpn_q  <= vpn_d;
    asid_q <= asid_d;
    ppn_q  <= ppn_d;
    size_q <= size_d;
  end

  assign lk_miss  = lk_miss_q;
  assign lk_exc   = lk_exc_q;
  assign lk_paddr = lk_paddr_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_tlb_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l1_tlb_mp
//  Purpose  : Self-checking bench for l1_tlb_mp: directed vector table,
//             hand-written eviction sequence, randomized traffic against a
//             behavioural reference model.
//  Revision : 1.0  initial
// ============================================================================
module tb_l1_tlb_mp;
  localparam int DEPTH = 16;
  localparam int PORTS = 2;
  localparam int PN_W  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  lk_req;
  logic [63:0] lk_vaddr;
  logic [1:0]  lk_miss, lk_exc;
  logic [67:0] lk_paddr;
  logic [1:0]  priv;
  logic        satp_mode, sum;
  logic [8:0]  satp_asid;
  logic        fill_we, fill_g, fill_u;
  logic [19:0] fill_vpn;
  logic [8:0]  fill_asid;
  logic [21:0] fill_ppn;
  logic [0:0]  fill_size;
  logic        flush_valid, flush_use_va, flush_use_as;
  logic [31:0] flush_vaddr;
  logic [8:0]  flush_asid;

  always #5 clk = ~clk;

  l1_tlb_mp dut (
    .clk(clk), .rst(rst), .lk_req(lk_req), .lk_vaddr(lk_vaddr),
    .lk_miss(lk_miss), .lk_exc(lk_exc), .lk_paddr(lk_paddr),
    .priv(priv), .satp_mode(satp_mode), .satp_asid(satp_asid), .sum(sum),
    .fill_we(fill_we), .fill_vpn(fill_vpn), .fill_asid(fill_asid),
    .fill_ppn(fill_ppn), .fill_size(fill_size), .fill_g(fill_g), .fill_u(fill_u),
    .flush_valid(flush_valid), .flush_use_va(flush_use_va),
    .flush_use_as(flush_use_as), .flush_vaddr(flush_vaddr), .flush_asid(flush_asid)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a list of translation records
  bit          m_valid [DEPTH];
  logic [19:0] m_vpn   [DEPTH];
  logic [8:0]  m_asid  [DEPTH];
  logic [21:0] m_ppn   [DEPTH];
  int          m_size  [DEPTH];
  bit          m_g     [DEPTH];
  bit          m_u     [DEPTH];
  int          m_rr;

  bit          e_miss [PORTS];
  bit          e_exc  [PORTS];
  bit          e_pchk [PORTS];
  logic [33:0] e_pa   [PORTS];

  function automatic bit same_page(logic [19:0] a, logic [19:0] b, int sz);
    return (a >> (sz*PN_W)) == (b >> (sz*PN_W));
  endfunction

  task automatic model_clear();
    for (int e = 0; e < DEPTH; e++) m_valid[e] = 1'b0;
    m_rr = 0;
  endtask

  // Predict next-cycle outputs from current inputs, then apply fill/flush.
  task automatic model_step();
    bit          byp, clr;
    int          h, victim;
    logic [31:0] va;
    longint      mask, pn, vn, pa;
    byp = (priv == 2'd3) || (satp_mode == 1'b0);
    for (int p = 0; p < PORTS; p++) begin
      va = lk_vaddr[p*32 +: 32];
      h  = -1;
      for (int e = 0; e < DEPTH; e++)
        if (h < 0 && m_valid[e] && (m_g[e] || m_asid[e] == satp_asid) &&
            same_page(m_vpn[e], va[31:12], m_size[e])) h = e;
      e_miss[p] = 1'b0; e_exc[p] = 1'b0; e_pchk[p] = 1'b0; e_pa[p] = '0;
      if (byp) begin
        e_pchk[p] = 1'b1;
        e_pa[p]   = {2'b00, va};
      end else if (h >= 0) begin
        mask = (longint'(1) << (PN_W*m_size[h])) - 1;
        pn   = longint'(m_ppn[h]);
        vn   = longint'(va[31:12]);
        pa   = (((pn & ~mask) | (vn & mask)) << 12) | longint'(va[11:0]);
        e_pa[p]   = pa[33:0];
        e_pchk[p] = 1'b1;
        e_exc[p]  = lk_req[p] && ((priv == 2'd1 && !sum && m_u[h]) ||
                                  (priv == 2'd0 && !m_u[h]));
      end else begin
        e_miss[p] = lk_req[p];
      end
    end
    victim = -1;
    if (fill_we) begin
      for (int e = 0; e < DEPTH; e++)
        if (victim < 0 && m_valid[e] && m_size[e] == int'(fill_size) &&
            m_asid[e] == fill_asid && same_page(m_vpn[e], fill_vpn, m_size[e])) victim = e;
      for (int e = 0; e < DEPTH; e++)
        if (victim < 0 && !m_valid[e]) victim = e;
      if (victim < 0) begin
        victim = m_rr;
        m_rr   = (m_rr + 1) % DEPTH;
      end
    end
    if (flush_valid) begin
      for (int e = 0; e < DEPTH; e++) begin
        clr = 1'b1;
        if (flush_use_va && !same_page(m_vpn[e], flush_vaddr[31:12], m_size[e])) clr = 1'b0;
        if (flush_use_as && (m_g[e] || m_asid[e] != flush_asid)) clr = 1'b0;
        if (clr) m_valid[e] = 1'b0;
      end
    end
    if (fill_we) begin
      m_valid[victim] = 1'b1; m_vpn[victim] = fill_vpn; m_asid[victim] = fill_asid;
      m_ppn[victim] = fill_ppn; m_size[victim] = int'(fill_size);
      m_g[victim] = fill_g; m_u[victim] = fill_u;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int p, input bit em, input bit ee,
                       input bit pchk, input logic [33:0] epa);
    logic [33:0] gpa;
    gpa = lk_paddr[p*34 +: 34];
    n_vec++;
    if (lk_miss[p] !== em || lk_exc[p] !== ee || (pchk && gpa !== epa)) begin
      n_bad++;
      $display("FAIL %s port%0d: got miss=%b exc=%b pa=%h, want miss=%b exc=%b pa=%h%s",
               name, p, lk_miss[p], lk_exc[p], gpa, em, ee, epa, pchk ? "" : " (pa unchecked)");
    end
  endtask

  task automatic check_model(input string name);
    for (int p = 0; p < PORTS; p++) check(name, p, e_miss[p], e_exc[p], e_pchk[p], e_pa[p]);
  endtask

  task automatic idle();
    fill_we = 0; fill_vpn = '0; fill_asid = '0; fill_ppn = '0; fill_size = '0;
    fill_g = 0; fill_u = 0; flush_valid = 0; flush_use_va = 0; flush_use_as = 0;
    flush_vaddr = '0; flush_asid = '0; lk_req = '0; lk_vaddr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    for (int p = 0; p < PORTS; p++) check("reset", p, 1'b0, 1'b0, 1'b1, 34'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic look(input logic [31:0] va0, input logic [31:0] va1);
    idle();
    lk_req = 2'b11; lk_vaddr = {va1, va0};
    tick();
  endtask

  task automatic fill(input logic [19:0] vpn, input logic [21:0] ppn);
    idle();
    fill_we = 1; fill_vpn = vpn; fill_ppn = ppn; fill_asid = 9'd5;
    tick();
  endtask

  typedef struct {
    bit fill; logic [19:0] f_vpn; logic [21:0] f_ppn; bit f_size; bit f_g; bit f_u;
    bit fl; bit fl_va; bit fl_as; logic [31:0] fl_addr;
    logic [1:0] pv; bit md; logic [8:0] as; bit sm; bit rq; logic [31:0] va;
    bit chk; bit x_miss; bit x_exc; bit x_pchk; logic [33:0] x_pa;
  } vec_t;

  localparam int NV = 27;
  vec_t tab [NV];

  function automatic logic [19:0] rnd_vpn();
    logic [9:0] hi, lo;
    case ($urandom_range(0, 2))
      0: hi = 10'h000;
      1: hi = 10'h001;
      default: hi = 10'h155;
    endcase
    case ($urandom_range(0, 3))
      0: lo = 10'h000;
      1: lo = 10'h001;
      2: lo = 10'h2AA;
      default: lo = 10'h3FF;
    endcase
    return {hi, lo};
  endfunction

  initial begin
    //          fill f_vpn     f_ppn     sz g u  fl va as fl_addr       pv md as sm rq va             chk m e pc pa
    tab[0]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00000000, 1, 1, 0, 1, 34'h0};
    tab[1]  = '{1, 20'h12345, 22'h0ABCD, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h12345678, 1, 1, 0, 0, 34'h0};
    tab[2]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h12345678, 1, 0, 0, 1, 34'h00ABCD678};
    tab[3]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 6, 0, 1, 32'h12345678, 1, 1, 0, 0, 34'h0};
    tab[4]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 5, 0, 1, 32'h12345678, 1, 0, 1, 1, 34'h00ABCD678};
    tab[5]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        3, 1, 5, 0, 1, 32'h12345678, 1, 0, 0, 1, 34'h012345678};
    tab[6]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 0, 5, 0, 1, 32'h12345678, 1, 0, 0, 1, 34'h012345678};
    tab[7]  = '{1, 20'h40000, 22'h100000,1, 0, 1, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h12345678, 1, 0, 0, 1, 34'h00ABCD678};
    tab[8]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h40123ABC, 1, 0, 1, 1, 34'h100123ABC};
    tab[9]  = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 1, 1, 32'h40123ABC, 1, 0, 0, 1, 34'h100123ABC};
    tab[10] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 5, 0, 1, 32'h40123ABC, 1, 0, 0, 1, 34'h100123ABC};
    tab[11] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 0, 32'h40123ABC, 1, 0, 0, 1, 34'h100123ABC};
    tab[12] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 0, 32'h77777000, 1, 0, 0, 0, 34'h0};
    tab[13] = '{1, 20'h00111, 22'h00222, 0, 1, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 0, 32'h0,        0, 0, 0, 0, 34'h0};
    tab[14] = '{1, 20'h00333, 22'h00444, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 0, 32'h0,        0, 0, 0, 0, 34'h0};
    tab[15] = '{0, 20'h0,     22'h0,     0, 0, 0, 1, 0, 1, 32'h0,        1, 1, 5, 0, 1, 32'h00333000, 1, 0, 0, 1, 34'h000444000};
    tab[16] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00333000, 1, 1, 0, 0, 34'h0};
    tab[17] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 6, 0, 1, 32'h00111ABC, 1, 0, 0, 1, 34'h000222ABC};
    tab[18] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h12345678, 1, 1, 0, 0, 34'h0};
    tab[19] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h40123ABC, 1, 1, 0, 0, 34'h0};
    tab[20] = '{1, 20'h00555, 22'h00666, 0, 0, 0, 1, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00111ABC, 1, 0, 0, 1, 34'h000222ABC};
    tab[21] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00555123, 1, 0, 0, 1, 34'h000666123};
    tab[22] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00111ABC, 1, 1, 0, 0, 34'h0};
    tab[23] = '{1, 20'h00777, 22'h00888, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00555123, 1, 0, 0, 1, 34'h000666123};
    tab[24] = '{0, 20'h0,     22'h0,     0, 0, 0, 1, 1, 0, 32'h00555000, 1, 1, 5, 0, 1, 32'h00777000, 1, 0, 0, 1, 34'h000888000};
    tab[25] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00555123, 1, 1, 0, 0, 34'h0};
    tab[26] = '{0, 20'h0,     22'h0,     0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 5, 0, 1, 32'h00777ABC, 1, 0, 0, 1, 34'h000888ABC};

    rst = 1'b0;
    idle();
    priv = 2'd1; satp_mode = 1'b1; satp_asid = 9'd5; sum = 1'b0;
    #2;
    do_reset();

    // Directed table
    for (int i = 0; i < NV; i++) begin
      idle();
      fill_we = tab[i].fill; fill_vpn = tab[i].f_vpn; fill_ppn = tab[i].f_ppn;
      fill_size = tab[i].f_size; fill_g = tab[i].f_g; fill_u = tab[i].f_u; fill_asid = 9'd5;
      flush_valid = tab[i].fl; flush_use_va = tab[i].fl_va; flush_use_as = tab[i].fl_as;
      flush_vaddr = tab[i].fl_addr; flush_asid = 9'd5;
      priv = tab[i].pv; satp_mode = tab[i].md; satp_asid = tab[i].as; sum = tab[i].sm;
      lk_req = {2{tab[i].rq}}; lk_vaddr = {tab[i].va, tab[i].va};
      tick();
      if (tab[i].chk)
        for (int p = 0; p < PORTS; p++)
          check($sformatf("tab%0d", i), p, tab[i].x_miss, tab[i].x_exc, tab[i].x_pchk, tab[i].x_pa);
    end

    // Eviction / round-robin / duplicate suppression
    priv = 2'd1; satp_mode = 1'b1; satp_asid = 9'd5; sum = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) fill(20'h01000 + 20'(i), 22'h02000 + 22'(i));
    fill(20'h1FFFF, 22'h3FFFF);
    look(32'h01000000, 32'h1FFFF000);
    check("evict_e0", 0, 1'b1, 1'b0, 1'b0, 34'h0);
    check("evict_new", 1, 1'b0, 1'b0, 1'b1, 34'h03FFFF000);
    look(32'h01001000, 32'h0100F000);
    check("keep_e1", 0, 1'b0, 1'b0, 1'b1, 34'h002001000);
    check("keep_e15", 1, 1'b0, 1'b0, 1'b1, 34'h00200F000);
    fill(20'h01005, 22'h0ABCD);
    look(32'h01005234, 32'h01001000);
    check("refill_dup", 0, 1'b0, 1'b0, 1'b1, 34'h00ABCD234);
    check("refill_no_alloc", 1, 1'b0, 1'b0, 1'b1, 34'h002001000);
    fill(20'h1EEEE, 22'h01111);
    look(32'h01001000, 32'h01002000);
    check("rr_next_e1", 0, 1'b1, 1'b0, 1'b0, 34'h0);
    check("rr_keep_e2", 1, 1'b0, 1'b0, 1'b1, 34'h002002000);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      priv      = 2'($urandom_range(0, 3));
      satp_mode = ($urandom_range(0, 7) != 0);
      satp_asid = 9'($urandom_range(1, 3));
      sum       = 1'($urandom_range(0, 1));
      lk_req    = 2'($urandom_range(0, 3));
      lk_vaddr  = {rnd_vpn(), 12'($urandom), rnd_vpn(), 12'($urandom)};
      fill_we   = ($urandom_range(0, 1) == 1);
      fill_vpn  = rnd_vpn();
      fill_asid = 9'($urandom_range(1, 3));
      fill_ppn  = 22'($urandom);
      fill_size = 1'($urandom_range(0, 1));
      fill_g    = ($urandom_range(0, 3) == 0);
      fill_u    = 1'($urandom_range(0, 1));
      flush_valid  = ($urandom_range(0, 24) == 0);
      flush_use_va = 1'($urandom_range(0, 1));
      flush_use_as = 1'($urandom_range(0, 1));
      flush_vaddr  = {rnd_vpn(), 12'($urandom)};
      flush_asid   = 9'($urandom_range(1, 3));
      tick();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
